// File: rtl/mlaccel_qpi_pkg.sv
// Definitions shared by the QPI host engine and the accelerator-side receiver:
// command opcodes and the host sequencing states.
package mlaccel_qpi_pkg;

  localparam logic [7:0] cmd_status = 8'h20;
  localparam logic [7:0] cmd_wreg   = 8'h21;
  localparam logic [7:0] cmd_rreg   = 8'h22;
  localparam logic [7:0] cmd_wmem   = 8'h23;
  localparam logic [7:0] cmd_rmem   = 8'h24;
  localparam logic [7:0] cmd_start  = 8'h25;
  localparam logic [7:0] cmd_stop   = 8'h26;

  typedef enum logic [2:0] {
    ST_GAP  = 3'd0,
    ST_IDLE = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_WAIT = 3'd4,
    ST_TURN = 3'd5,
    ST_HOLD = 3'd6
  } host_state_t;

endpackage

// File: rtl/mlaccel_qpi_host.sv
// QPI initiator: one byte per 2*HALF clocks (high nibble on the rising qpi_clk edge); read data returns
// 2*HALF after accept (3*HALF after a write->read turnaround); cmd_ready is high only in IDLE/WAIT.
module mlaccel_qpi_host
  import mlaccel_qpi_pkg::*;
#(
  parameter int HALF = 4,
  parameter int GAP  = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_last,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       qpi_csb,
  output logic       qpi_clk,
  output logic [3:0] qpi_io_do,
  output logic [3:0] qpi_io_oe,
  input  logic [3:0] qpi_io_di
);

  localparam int MAXD = (HALF > GAP) ? HALF : GAP;
  localparam int DW   = $clog2(MAXD) + 1;
  localparam logic [DW-1:0] HALF_C = DW'(HALF);
  localparam logic [DW-1:0] GAP_C  = DW'(GAP);
  localparam logic [DW-1:0] ONE_C  = DW'(1);

  host_state_t   r_state;
  host_state_t   w_nxt;
  logic [DW-1:0] r_div;

  logic       r_rd;
  logic       r_last;
  logic [7:0] r_data;
  logic [3:0] r_rd_hi;

  logic       r_csb;
  logic       r_clk;
  logic [3:0] r_oe;
  logic [3:0] r_do;
  logic       r_rsp_vld;
  logic [7:0] r_rsp_dat;

  logic       w_acc;
  logic       w_exp;
  logic       w_rd_n;
  logic [7:0] w_data_n;
  logic       w_csb_n;
  logic       w_clk_n;
  logic [3:0] w_oe_n;
  logic [3:0] w_do_n;

  assign cmd_ready = (r_state == ST_IDLE) || (r_state == ST_WAIT);
  assign busy      = (r_state != ST_IDLE);
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_exp     = (r_div == ONE_C);
  assign w_rd_n    = w_acc ? cmd_read : r_rd;
  assign w_data_n  = w_acc ? cmd_data : r_data;

  assign qpi_csb   = r_csb;
  assign qpi_clk   = r_clk;
  assign qpi_io_oe = r_oe;
  assign qpi_io_do = r_do;
  assign rsp_valid = r_rsp_vld;
  assign rsp_data  = r_rsp_dat;

  // Every timed state lasts exactly dur() cycles; the counter is reloaded on each state change.
  function automatic logic [DW-1:0] dur(input host_state_t s);
    logic [DW-1:0] d;
    case (s)
      ST_GAP:                         d = GAP_C;
      ST_LO, ST_HI, ST_TURN, ST_HOLD: d = HALF_C;
      default:                        d = '0;
    endcase
    return d;
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_GAP;
      r_div   <= GAP_C;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        r_div <= dur(w_nxt);
      end else if (r_div != '0) begin
        r_div <= r_div - ONE_C;
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_GAP:  if (w_exp) w_nxt = ST_IDLE;
      ST_IDLE: if (cmd_valid) w_nxt = ST_LO;
      // A read following a write needs a released-bus half-period first.
      ST_WAIT: if (cmd_valid) w_nxt = (cmd_read && !r_rd) ? ST_TURN : ST_LO;
      ST_TURN: if (w_exp) w_nxt = ST_LO;
      ST_LO:   if (w_exp) w_nxt = ST_HI;
      ST_HI:   if (w_exp) w_nxt = r_last ? ST_HOLD : ST_WAIT;
      ST_HOLD: if (w_exp) w_nxt = ST_GAP;
      default: w_nxt = ST_GAP;
    endcase
  end

  // Pin values are derived from the next state so they can be registered without a cycle of lag.
  always_comb begin
    w_csb_n = 1'b1;
    w_clk_n = 1'b0;
    w_oe_n  = 4'h0;
    w_do_n  = 4'h0;
    case (w_nxt)
      ST_LO: begin
        w_csb_n = 1'b0;
        if (!w_rd_n) begin
          w_oe_n = 4'hF;
          w_do_n = w_data_n[7:4];
        end
      end
      ST_HI: begin
        w_csb_n = 1'b0;
        w_clk_n = 1'b1;
        if (!w_rd_n) begin
          w_oe_n = 4'hF;
          w_do_n = w_data_n[3:0];
        end
      end
      ST_WAIT, ST_TURN, ST_HOLD: w_csb_n = 1'b0;
      default: w_csb_n = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_csb     <= 1'b1;
      r_clk     <= 1'b0;
      r_oe      <= 4'h0;
      r_do      <= 4'h0;
      r_rd      <= 1'b0;
      r_last    <= 1'b0;
      r_data    <= 8'h00;
      r_rd_hi   <= 4'h0;
      r_rsp_vld <= 1'b0;
      r_rsp_dat <= 8'h00;
    end else begin
      r_csb     <= w_csb_n;
      r_clk     <= w_clk_n;
      r_oe      <= w_oe_n;
      r_do      <= w_do_n;
      r_rsp_vld <= 1'b0;
      if (w_acc) begin
        r_rd   <= cmd_read;
        r_last <= cmd_last;
        r_data <= cmd_data;
      end
      // Sample at the end of each half-period, just before the edge that ends it.
      if (r_rd && w_exp && (r_state == ST_LO)) begin
        r_rd_hi <= qpi_io_di;
      end
      if (r_rd && w_exp && (r_state == ST_HI)) begin
        r_rsp_dat <= {r_rd_hi, qpi_io_di};
        r_rsp_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mlaccel_qpi_host.sv
// Directed bench for mlaccel_qpi_host: two instances (HALF=4/GAP=8 and HALF=2/GAP=1), a wire-level
// receiver model per instance, and scoreboards for written bytes and read responses.
module tb_mlaccel_qpi_host;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [1:0]      cmd_valid, cmd_ready, cmd_read, cmd_last;
  logic [1:0][7:0] cmd_data, rsp_data, rd_byte;
  logic [1:0]      rsp_valid, busy, qpi_csb, qpi_clk;
  logic [1:0][3:0] qpi_io_do, qpi_io_oe;
  logic [1:0]      first_pend;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  exp_wr[$];
  logic [31:0] exp_rd[$];

  int last_low[2], last_rdy[2], rises[2], csb_rises[2], oe_cnt[2], oe_bad[2];
  int gc[2];
  int gap, r0, c0, o0, h, gp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gi
      localparam int H = (g == 0) ? 4 : 2;
      localparam int G = (g == 0) ? 8 : 1;
      logic [3:0]  di;
      logic        p_clk = 1'b0, p_csb = 1'b1, first = 1'b0;
      logic [3:0]  p_do = 4'h0, p_oe = 4'h0, nib = 4'h0;
      logic [31:0] e;
      int          run = 0, run_rdy = 0;

      // Receiver drives the high nibble while qpi_clk is low and the low nibble while it is high.
      assign di = (qpi_io_oe[g] != 4'h0) ? 4'h0 : (qpi_clk[g] ? rd_byte[g][3:0] : rd_byte[g][7:4]);

      mlaccel_qpi_host #(.HALF(H), .GAP(G)) u_dut (
        .clock     (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid[g]),
        .cmd_ready (cmd_ready[g]),
        .cmd_read  (cmd_read[g]),
        .cmd_last  (cmd_last[g]),
        .cmd_data  (cmd_data[g]),
        .rsp_valid (rsp_valid[g]),
        .rsp_data  (rsp_data[g]),
        .busy      (busy[g]),
        .qpi_csb   (qpi_csb[g]),
        .qpi_clk   (qpi_clk[g]),
        .qpi_io_do (qpi_io_do[g]),
        .qpi_io_oe (qpi_io_oe[g]),
        .qpi_io_di (di)
      );

      initial begin
        last_low[g] = 0; last_rdy[g] = 0; rises[g] = 0;
        csb_rises[g] = 0; oe_cnt[g] = 0; oe_bad[g] = 0;
      end

      always @(negedge clk) begin
        if (p_csb && !qpi_csb[g]) first = 1'b1;
        if (qpi_clk[g] && !p_clk) begin
          nib = p_do;
          rises[g]++;
        end
        if (!qpi_clk[g] && p_clk) begin
          if (p_oe == 4'hF) begin
            e = (exp_wr.size() > 0) ? {23'd0, exp_wr.pop_front()} : 'x;
            check("wr_byte", {23'd0, first, nib, p_do}, e);
          end
          first = 1'b0;
        end
        if (qpi_io_oe[g] != 4'h0) oe_cnt[g]++;
        if (qpi_io_oe[g] != 4'h0 && qpi_io_oe[g] != 4'hF) oe_bad[g]++;
        if (!qpi_csb[g]) begin
          run++;
          if (cmd_ready[g]) run_rdy++;
        end else if (!p_csb) begin
          last_low[g] = run;
          last_rdy[g] = run_rdy;
          csb_rises[g]++;
          run = 0;
          run_rdy = 0;
        end
        if (rsp_valid[g]) begin
          e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 'x;
          check("rsp", {cyc[23:0], rsp_data[g]}, e);
        end
        p_clk = qpi_clk[g];
        p_csb = qpi_csb[g];
        p_do  = qpi_io_do[g];
        p_oe  = qpi_io_oe[g];
      end
    end
  endgenerate

  // lat = clock edges from the accepting edge to the edge that raises rsp_valid.
  task automatic send(input int gi_, input bit rd, input bit last, input logic [7:0] d, input int lat);
    int t = 0;
    @(negedge clk);
    cmd_valid[gi_] = 1'b1;
    cmd_read[gi_]  = rd;
    cmd_last[gi_]  = last;
    cmd_data[gi_]  = rd ? 8'h00 : d;
    while (!cmd_ready[gi_] && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("accept_rdy", {31'd0, cmd_ready[gi_]}, 32'd1);
    if (rd) begin
      rd_byte[gi_] = d;
      exp_rd.push_back({24'(cyc + 1 + lat), d});
    end else begin
      exp_wr.push_back({first_pend[gi_], d});
    end
    first_pend[gi_] = last;
    @(posedge clk);
    #1;
    cmd_valid[gi_] = 1'b0;
  endtask

  task automatic wait_idle(input int gi_, output int gap_o);
    int t = 0;
    gap_o = 0;
    while (qpi_csb[gi_] == 1'b0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    while (!cmd_ready[gi_] && gap_o < 1000) begin
      gap_o++;
      @(negedge clk);
    end
    check("idle_reached", {31'd0, cmd_ready[gi_]}, 32'd1);
  endtask

  initial begin
    cmd_valid = '0; cmd_read = '0; cmd_last = '0; cmd_data = '0; rd_byte = '0;
    first_pend = 2'b11;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_csb", {31'd0, qpi_csb[i]}, 32'd1);
      check("rst_clk", {31'd0, qpi_clk[i]}, 32'd0);
      check("rst_oe", {28'd0, qpi_io_oe[i]}, 32'd0);
      check("rst_do", {28'd0, qpi_io_do[i]}, 32'd0);
      check("rst_rspv", {31'd0, rsp_valid[i]}, 32'd0);
      check("rst_rspd", {24'd0, rsp_data[i]}, 32'd0);
      check("rst_rdy", {31'd0, cmd_ready[i]}, 32'd0);
      check("rst_busy", {31'd0, busy[i]}, 32'd1);
    end
    resetn = 1'b1;
    gc[0] = 0; gc[1] = 0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++) if (!cmd_ready[i]) gc[i]++;
      @(negedge clk);
    end
    check("rst_gap0", gc[0], 32'd8);
    check("rst_gap1", gc[1], 32'd1);

    for (int i = 0; i < 2; i++) begin
      h  = (i == 0) ? 4 : 2;
      gp = (i == 0) ? 8 : 1;
      // single write with last
      r0 = rises[i];
      send(i, 1'b0, 1'b1, 8'h25, 0);
      wait_idle(i, gap);
      check("s1_csb_low", last_low[i], 3 * h);
      check("s1_rdy_in_txn", last_rdy[i], 0);
      check("s1_gap", gap, gp);
      check("s1_rises", rises[i] - r0, 1);
      // back-to-back writes, one transaction
      r0 = rises[i];
      c0 = csb_rises[i];
      send(i, 1'b0, 1'b0, 8'h23, 0);
      send(i, 1'b0, 1'b0, 8'h00, 0);
      send(i, 1'b0, 1'b0, 8'h10, 0);
      send(i, 1'b0, 1'b1, 8'h01, 0);
      wait_idle(i, gap);
      check("s2_csb_low", last_low[i], 3 * (2 * h + 1) + 3 * h);
      check("s2_rises", rises[i] - r0, 4);
      check("s2_csb_rises", csb_rises[i] - c0, 1);
      check("s2_gap", gap, gp);
      // write then read: turnaround inserted
      send(i, 1'b0, 1'b0, 8'h20, 0);
      send(i, 1'b1, 1'b1, 8'hA5, 3 * h);
      wait_idle(i, gap);
      check("s3_csb_low", last_low[i], 6 * h + 1);
      check("s3_rsp_data", {24'd0, rsp_data[i]}, 32'hA5);
    end

    // consecutive reads never drive the bus
    o0 = oe_cnt[0];
    send(0, 1'b1, 1'b0, 8'h11, 8);
    send(0, 1'b1, 1'b0, 8'h22, 8);
    send(0, 1'b1, 1'b0, 8'h33, 8);
    send(0, 1'b1, 1'b1, 8'h44, 8);
    wait_idle(0, gap);
    check("s4_oe", oe_cnt[0] - o0, 0);
    check("s4_rsp_hold", {24'd0, rsp_data[0]}, 32'h44);
    check("s4_rd_empty", exp_rd.size(), 0);

    // reset in the middle of LO of a write
    send(0, 1'b0, 1'b0, 8'h21, 0);
    void'(exp_wr.pop_back());
    first_pend[0] = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("s5_csb", {31'd0, qpi_csb[0]}, 32'd1);
    check("s5_oe", {28'd0, qpi_io_oe[0]}, 32'd0);
    check("s5_clk", {31'd0, qpi_clk[0]}, 32'd0);
    check("s5_rspd", {24'd0, rsp_data[0]}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    gap = 0;
    while (!cmd_ready[0] && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    check("s5_gap", gap, 8);
    send(0, 1'b0, 1'b1, 8'h26, 0);
    wait_idle(0, gap);
    check("s5_csb_low", last_low[0], 12);

    repeat (4) @(negedge clk);
    check("end_wr_empty", exp_wr.size(), 0);
    check("end_rd_empty", exp_rd.size(), 0);
    check("end_oe_bad", oe_bad[0] + oe_bad[1], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
